// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
//   fetch_state_t : fetch sequencer states
//   fetch_entry_t : one buffered fetch result, {pc, instr}
package cpu_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  // Encoding that ends instruction fetch.
  localparam logic [31:0] HALT_ENCODE  = 32'h0000_003F;
  // Value driven on the instruction bus when nothing is presented.
  localparam logic [31:0] FIRST_ENCODE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch results with flush.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push, din  : enqueue; accepted when not full or when popping the same cycle
//   pop, dout  : dequeue; dout is the head entry
//   count, full, empty : occupancy status
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers returned
// words and hands them to decode over valid/ready.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : leave IDLE and begin fetching
//   redirect_valid/_pc        : new fetch address, flushes buffered/in-flight words
//   imem_req/_addr/_rdata     : instruction memory, data returns 1 cycle after req
//   instr_valid/instr/instr_pc/instr_ready : decode handshake
//   halted                    : halt word consumed, fetch stopped
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_WORD  = HALT_ENCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, infl_addr;
  logic         in_flight;

  fetch_entry_t fifo_din, fifo_dout, head;
  logic [AW:0]  count, occ;
  logic         full, empty, push, pop;
  logic         redirect_act, resp_ok, xfer, halt_arrive, halt_xfer;

  logic [1:0]   unused_rp_lo;
  assign unused_rp_lo = redirect_pc[1:0];

  assign redirect_act = redirect_valid && (state == FETCH || state == DRAIN);
  // A response arriving in a redirect cycle belongs to the old path.
  assign resp_ok      = in_flight && !redirect_act;
  assign fifo_din     = '{pc: infl_addr, instr: imem_rdata};
  // Empty buffer: the arriving word is presented straight away.
  assign head         = empty ? fifo_din : fifo_dout;
  assign xfer         = instr_valid && instr_ready;
  assign pop          = !empty && instr_ready;
  assign push         = resp_ok && !(empty && instr_ready);
  assign halt_arrive  = resp_ok && (imem_rdata == HALT_WORD);
  assign halt_xfer    = xfer && (head.instr == HALT_WORD);
  // Occupancy once this cycle's transfer leaves; keeps 1 word/cycle streaming.
  assign occ          = count + {{AW{1'b0}}, in_flight} - {{AW{1'b0}}, xfer};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_act),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      in_flight <= 1'b0;
      infl_addr <= '0;
    end else begin
      state     <= state_nxt;
      in_flight <= imem_req;
      if (imem_req) infl_addr <= pc;
      if (redirect_act)  pc <= {redirect_pc[31:2], 2'b00};
      else if (imem_req) pc <= pc + 32'd4;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = FETCH;
      FETCH:  if (!redirect_act && halt_arrive)
                state_nxt = halt_xfer ? HALTED : DRAIN;
      DRAIN:  if (redirect_act)   state_nxt = FETCH;
              else if (halt_xfer) state_nxt = HALTED;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    imem_req    = (state == FETCH) && !redirect_act && !halt_arrive &&
                  (occ < (AW+1)'(FIFO_DEPTH));
    imem_addr   = pc;
    instr_valid = !empty || resp_ok;
    instr       = instr_valid ? head.instr : FIRST_ENCODE;
    instr_pc    = instr_valid ? head.pc : '0;
    halted      = (state == HALTED);
  end

endmodule
